// File: rtl/cache_nway_pkg.sv
// -----------------------------------------------------------------------------
// cache_nway_pkg
// Shared types for the N-way set-associative LC-3b cache:
//   lc3b_word       16-bit CPU word / address
//   mem_bus         128-bit cache line as seen by physical memory
//   lc3b_mem_wmask  per-byte write enables for a CPU write
//   cache_state_t   controller states (CHECK / WRITEBACK / FILL)
// plus the byte-merge helper used on write hits.
// -----------------------------------------------------------------------------
package cache_nway_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] mem_bus;
  typedef logic [1:0]   lc3b_mem_wmask;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } cache_state_t;

  // A line is 16 bytes, i.e. 8 words addressed by mem_address[3:1].
  localparam int OFFSET_BITS = 4;

  // Replace only the byte lanes enabled by be; other lanes keep old data.
  function automatic lc3b_word merge_bytes(input lc3b_word      old_word,
                                           input lc3b_word      new_word,
                                           input lc3b_mem_wmask be);
    return {(be[1] ? new_word[15:8] : old_word[15:8]),
            (be[0] ? new_word[7:0]  : old_word[7:0])};
  endfunction

endpackage

// File: rtl/cache_nway_plru.sv
// -----------------------------------------------------------------------------
// plru_tree
// Purely combinational tree pseudo-LRU for one set.
// Node numbering is heap order: node 0 is the root, node n has children
// 2n+1 (left, lower ways) and 2n+2 (right, upper ways). A node bit of 0
// points the victim search left, 1 points it right.
// Ports:
//   plru_bits_i   current WAYS-1 tree bits of the indexed set
//   access_way_i  way being accessed this cycle
//   victim_o      way reached by following the pointers
//   next_bits_o   tree bits after marking access_way_i most recently used
// -----------------------------------------------------------------------------
module plru_tree
  import cache_nway_pkg::*;
#(
  parameter  int WAYS     = 4,
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]     plru_bits_i,
  input  logic [WAY_BITS-1:0] access_way_i,
  output logic [WAY_BITS-1:0] victim_o,
  output logic [WAYS-2:0]     next_bits_o
);

  // Walk root to leaf; at level l the node index is (2^l - 1) plus the
  // way-number prefix already decided by the levels above.
  always_comb begin
    logic [WAY_BITS-1:0] vic;
    logic [WAY_BITS-1:0] node;
    vic  = '0;
    node = '0;
    for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
      node = WAY_BITS'((1 << lvl) - 1) + (vic >> (WAY_BITS - lvl));
      vic[WAY_BITS-1-lvl] = plru_bits_i[node];
    end
    victim_o = vic;
  end

  // Every node on the accessed way's path is made to point away from it.
  always_comb begin
    logic [WAY_BITS-1:0] node;
    next_bits_o = plru_bits_i;
    node        = '0;
    for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
      node = WAY_BITS'((1 << lvl) - 1) + (access_way_i >> (WAY_BITS - lvl));
      next_bits_o[node] = ~access_way_i[WAY_BITS-1-lvl];
    end
  end

endmodule

// File: rtl/cache_nway.sv
// -----------------------------------------------------------------------------
// cache_nway
// N-way set-associative, write-back, write-allocate cache between the LC-3b
// CPU memory port and physical memory. Arrays are flops so hits resolve in
// the request cycle; misses go through an optional WRITEBACK then FILL.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   mem_read/mem_write              CPU request, held until mem_resp
//   mem_address/mem_wdata           CPU byte address / write data
//   mem_byte_enable                 byte lanes for a write
//   mem_rdata/mem_resp              read word / one-cycle completion
//   pmem_read/pmem_write            line fill / writeback request (registered)
//   pmem_address/pmem_wdata         line address / victim line
//   pmem_rdata/pmem_resp            fill line / memory done
// -----------------------------------------------------------------------------
module cache_nway
  import cache_nway_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  input  lc3b_mem_wmask mem_byte_enable,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output mem_bus        pmem_wdata,
  input  mem_bus        pmem_rdata,
  input  logic          pmem_resp
);

  localparam int INDEX_BITS = $clog2(SETS);
  localparam int TAG_BITS   = 16 - OFFSET_BITS - INDEX_BITS;
  localparam int WAY_BITS   = $clog2(WAYS);

  // Storage
  mem_bus                data_q  [SETS][WAYS];
  logic [TAG_BITS-1:0]   tag_q   [SETS][WAYS];
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];
  logic [WAYS-2:0]       plru_q  [SETS];

  // Control state
  cache_state_t          state_q, state_d;
  logic [WAY_BITS-1:0]   victim_q, victim_d;
  logic                  pmem_read_q, pmem_read_d;
  logic                  pmem_write_q, pmem_write_d;
  lc3b_word              pmem_address_q, pmem_address_d;

  // Request decode
  logic [TAG_BITS-1:0]   tag_s;
  logic [INDEX_BITS-1:0] idx_s;
  logic [2:0]            word_s;
  logic                  req_s;
  logic                  hit_s;
  logic [WAY_BITS-1:0]   hit_way_s;
  logic                  cpu_hit_s;
  mem_bus                line_s;
  mem_bus                wline_s;
  logic                  inv_found_s;
  logic [WAY_BITS-1:0]   inv_way_s;
  logic [WAY_BITS-1:0]   plru_victim_s;
  logic [WAY_BITS-1:0]   miss_victim_s;
  logic [WAYS-2:0]       plru_next_s;
  logic                  unused_addr_bit_s;

  assign tag_s             = mem_address[15:OFFSET_BITS+INDEX_BITS];
  assign idx_s             = mem_address[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign word_s            = mem_address[3:1];
  assign unused_addr_bit_s = mem_address[0];
  assign req_s             = mem_read | mem_write;

  // Tag compare across the indexed set; at most one valid way can match.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s)) begin
        hit_s     = 1'b1;
        hit_way_s = WAY_BITS'(w);
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Lowest-numbered invalid way wins over the PLRU choice.
  always_comb begin
    inv_found_s = 1'b0;
    inv_way_s   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx_s][w]) begin
        inv_found_s = 1'b1;
        inv_way_s   = WAY_BITS'(w);
      end else begin
        inv_found_s = inv_found_s;
      end
    end
  end

  plru_tree #(.WAYS(WAYS)) u_plru (
    .plru_bits_i  (plru_q[idx_s]),
    .access_way_i (hit_way_s),
    .victim_o     (plru_victim_s),
    .next_bits_o  (plru_next_s)
  );

  assign miss_victim_s = inv_found_s ? inv_way_s : plru_victim_s;
  assign cpu_hit_s     = (state_q == CHECK) && req_s && hit_s;

  assign line_s    = data_q[idx_s][hit_way_s];
  assign mem_rdata = line_s[{word_s, 4'b0000} +: 16];
  assign mem_resp  = cpu_hit_s;

  // Hit line with the CPU write data merged into the addressed word.
  always_comb begin
    wline_s = line_s;
    wline_s[{word_s, 4'b0000} +: 16] =
      merge_bytes(line_s[{word_s, 4'b0000} +: 16], mem_wdata, mem_byte_enable);
  end

  // Next-state and next registered pmem outputs.
  always_comb begin
    state_d        = state_q;
    victim_d       = victim_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    case (state_q)
      CHECK: begin
        if (req_s && !hit_s) begin
          victim_d = miss_victim_s;
          if (valid_q[idx_s][miss_victim_s] && dirty_q[idx_s][miss_victim_s]) begin
            state_d        = WRITEBACK;
            pmem_write_d   = 1'b1;
            pmem_address_d = {tag_q[idx_s][miss_victim_s], idx_s, 4'b0000};
          end else begin
            state_d        = FILL;
            pmem_read_d    = 1'b1;
            pmem_address_d = {tag_s, idx_s, 4'b0000};
          end
        end else begin
          state_d = CHECK;
        end
      end
      WRITEBACK: begin
        if (pmem_resp) begin
          state_d        = FILL;
          pmem_write_d   = 1'b0;
          pmem_read_d    = 1'b1;
          pmem_address_d = {tag_s, idx_s, 4'b0000};
        end else begin
          state_d = WRITEBACK;
        end
      end
      FILL: begin
        if (pmem_resp) begin
          state_d     = CHECK;
          pmem_read_d = 1'b0;
        end else begin
          state_d = FILL;
        end
      end
      default: begin
        state_d      = CHECK;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  // Controller registers, including the Moore pmem request outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= CHECK;
      victim_q       <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= 16'h0000;
    end else begin
      state_q        <= state_d;
      victim_q       <= victim_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
    end
  end

  // Valid / dirty / PLRU bookkeeping; reset drops any pending dirty data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (cpu_hit_s) begin
      plru_q[idx_s] <= plru_next_s;
      if (mem_write) begin
        dirty_q[idx_s][hit_way_s] <= 1'b1;
      end
    end else if ((state_q == WRITEBACK) && pmem_resp) begin
      dirty_q[idx_s][victim_q] <= 1'b0;
    end else if ((state_q == FILL) && pmem_resp) begin
      valid_q[idx_s][victim_q] <= 1'b1;
      dirty_q[idx_s][victim_q] <= 1'b0;
    end
  end

  // Line data and tags carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (cpu_hit_s && mem_write) begin
      data_q[idx_s][hit_way_s] <= wline_s;
    end else if ((state_q == FILL) && pmem_resp) begin
      data_q[idx_s][victim_q] <= pmem_rdata;
      tag_q[idx_s][victim_q]  <= tag_s;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = data_q[idx_s][victim_q];

endmodule

// File: tb/tb_cache_nway.sv
// -----------------------------------------------------------------------------
// tb_cache_nway
// Scoreboard bench: a 4-way and a 2-way cache share one stimulus port,
// selected by sel. Expected CPU responses and expected pmem requests are
// queued when stimulus is issued; a monitor and a memory responder pop and
// compare as the selected DUT presents them.
// -----------------------------------------------------------------------------
module tb_cache_nway;
  import cache_nway_pkg::*;

  typedef struct {
    logic     is_read;
    lc3b_word addr;
    lc3b_word data;
    int       lat;    // 0 none, 1 same cycle as issue, 2 one after pmem_resp
  } cpu_exp_t;

  typedef struct {
    logic     is_write;
    lc3b_word addr;
    lc3b_word word2;
  } pmem_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          sel;
  logic          b_read, b_write;
  lc3b_word      b_addr, b_wdata;
  lc3b_mem_wmask b_be;
  mem_bus        b_prdata;
  logic          b_presp;

  lc3b_word d0_rdata, d1_rdata, d0_paddr, d1_paddr;
  logic     d0_resp, d1_resp, d0_pread, d1_pread, d0_pwrite, d1_pwrite;
  mem_bus   d0_pwdata, d1_pwdata;

  cache_nway #(.WAYS(4), .SETS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(b_read & ~sel), .mem_write(b_write & ~sel),
    .mem_address(b_addr), .mem_wdata(b_wdata), .mem_byte_enable(b_be),
    .mem_rdata(d0_rdata), .mem_resp(d0_resp),
    .pmem_read(d0_pread), .pmem_write(d0_pwrite), .pmem_address(d0_paddr),
    .pmem_wdata(d0_pwdata), .pmem_rdata(b_prdata), .pmem_resp(b_presp & ~sel)
  );

  cache_nway #(.WAYS(2), .SETS(8)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .mem_read(b_read & sel), .mem_write(b_write & sel),
    .mem_address(b_addr), .mem_wdata(b_wdata), .mem_byte_enable(b_be),
    .mem_rdata(d1_rdata), .mem_resp(d1_resp),
    .pmem_read(d1_pread), .pmem_write(d1_pwrite), .pmem_address(d1_paddr),
    .pmem_wdata(d1_pwdata), .pmem_rdata(b_prdata), .pmem_resp(b_presp & sel)
  );

  lc3b_word o_rdata, o_paddr;
  logic     o_resp, o_pread, o_pwrite;
  mem_bus   o_pwdata;
  assign o_rdata  = sel ? d1_rdata  : d0_rdata;
  assign o_resp   = sel ? d1_resp   : d0_resp;
  assign o_pread  = sel ? d1_pread  : d0_pread;
  assign o_pwrite = sel ? d1_pwrite : d0_pwrite;
  assign o_paddr  = sel ? d1_paddr  : d0_paddr;
  assign o_pwdata = sel ? d1_pwdata : d0_pwdata;

  cpu_exp_t  cq[$];
  pmem_exp_t pq[$];
  mem_bus    store [lc3b_word];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int req_cyc = 0;
  int presp_cyc = -10;
  int stall = 0;
  logic stall_bad = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory contents: word k of an untouched line is line_address | k.
  function automatic mem_bus line_of(input lc3b_word a);
    mem_bus l;
    if (store.exists(a)) return store[a];
    for (int k = 0; k < 8; k++) l[k*16 +: 16] = a | 16'(k);
    return l;
  endfunction

  task automatic exp_fill(input lc3b_word a);
    pmem_exp_t e;
    e.is_write = 1'b0; e.addr = a; e.word2 = 16'h0000;
    pq.push_back(e);
  endtask

  task automatic exp_wb(input lc3b_word a, input lc3b_word w2);
    pmem_exp_t e;
    e.is_write = 1'b1; e.addr = a; e.word2 = w2;
    pq.push_back(e);
  endtask

  // Issue one CPU request and hold it until mem_resp (bounded).
  task automatic cpu_req(input logic rd, input logic wr, input lc3b_word a,
                         input lc3b_word wd, input lc3b_mem_wmask be,
                         input lc3b_word exp, input int lat);
    cpu_exp_t e;
    logic got;
    e.is_read = rd & ~wr; e.addr = a; e.data = exp; e.lat = lat;
    cq.push_back(e);
    b_read = rd; b_write = wr; b_addr = a; b_wdata = wd; b_be = be;
    req_cyc = cyc;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = o_resp;
    end
    if (!got) begin
      checks++;
      $display("FAIL req_timeout: addr %0h got no mem_resp expected one", a);
      if (cq.size() > 0) e = cq.pop_back();
    end
    @(posedge clk); #1;
    b_read = 1'b0; b_write = 1'b0;
  endtask

  // CPU-side monitor.
  initial begin
    cpu_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_resp) begin
        if (cq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_resp: got mem_resp at addr %0h expected none", b_addr);
        end else begin
          e = cq.pop_front();
          if (e.is_read) check($sformatf("rdata@%0h", e.addr), 128'(o_rdata), 128'(e.data));
          if (e.lat == 1) check($sformatf("hit_lat@%0h", e.addr), 128'(cyc), 128'(req_cyc));
          else if (e.lat == 2) check($sformatf("fill_lat@%0h", e.addr), 128'(cyc), 128'(presp_cyc + 1));
        end
      end
    end
  end

  // Physical memory responder with configurable stall.
  initial begin
    pmem_exp_t e;
    lc3b_word  a;
    logic      rd, aborted;
    b_presp  = 1'b0;
    b_prdata = '0;
    forever begin
      @(negedge clk);
      b_presp = 1'b0;
      if (rst_n && (o_pread || o_pwrite)) begin
        check("pmem_rd_wr_exclusive", 128'(o_pread & o_pwrite), 128'(0));
        if (pq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pmem: got rd=%0b wr=%0b addr %0h expected none",
                   o_pread, o_pwrite, o_paddr);
        end else begin
          e = pq.pop_front();
          check("pmem_is_write", 128'(o_pwrite), 128'(e.is_write));
          check("pmem_addr", 128'(o_paddr), 128'(e.addr));
          if (e.is_write) check("wb_word2", 128'(o_pwdata[47:32]), 128'(e.word2));
        end
        a = o_paddr; rd = o_pread; aborted = 1'b0;
        for (int k = 0; k < stall; k++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (o_pread !== rd || o_paddr !== a || o_resp) stall_bad = 1'b1;
        end
        if (!aborted) begin
          if (o_pwrite) store[a] = o_pwdata;
          else b_prdata = line_of(a);
          b_presp   = 1'b1;
          presp_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_bus l;
    logic   seen;
    l = line_of(16'h1230);
    l[47:32] = 16'hBEEF;
    store[16'h1230] = l;

    sel = 1'b0; b_read = 1'b1; b_write = 1'b0; b_addr = 16'h1234;
    b_wdata = 16'h0000; b_be = 2'b00; rst_n = 1'b0;
    #12;
    check("rst_pmem_read", 128'(d0_pread), 128'(0));
    check("rst_pmem_write", 128'(d0_pwrite), 128'(0));
    check("rst_mem_resp", 128'(d0_resp), 128'(0));
    check("rst_pmem_addr", 128'(d0_paddr), 128'(16'h0000));
    b_read = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold read miss, then write-hit merge and read-back.
    exp_fill(16'h1230);
    cpu_req(1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 16'hBEEF, 2);
    cpu_req(1'b0, 1'b1, 16'h1234, 16'h00AA, 2'b01, 16'h0000, 1);
    cpu_req(1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 16'hBEAA, 1);

    // Fill ways 1..3 of set 3, then evict dirty way 0.
    exp_fill(16'h12B0); cpu_req(1'b1, 1'b0, 16'h12B4, 16'h0000, 2'b00, 16'h12B2, 2);
    exp_fill(16'h1330); cpu_req(1'b1, 1'b0, 16'h1334, 16'h0000, 2'b00, 16'h1332, 2);
    exp_fill(16'h13B0); cpu_req(1'b1, 1'b0, 16'h13B4, 16'h0000, 2'b00, 16'h13B2, 2);
    exp_wb(16'h1230, 16'hBEAA);
    exp_fill(16'h1430); cpu_req(1'b1, 1'b0, 16'h1434, 16'h0000, 2'b00, 16'h1432, 2);

    // Stalled fill: PLRU now points at clean way 2.
    stall = 20; stall_bad = 1'b0;
    exp_fill(16'h1530); cpu_req(1'b1, 1'b0, 16'h1534, 16'h0000, 2'b00, 16'h1532, 2);
    check("stall_hold", 128'(stall_bad), 128'(0));
    stall = 0;

    // Evicted line comes back with the written-back data; way 0 still hits.
    exp_fill(16'h1230); cpu_req(1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 16'hBEAA, 2);
    cpu_req(1'b1, 1'b0, 16'h1434, 16'h0000, 2'b00, 16'h1432, 1);

    // Reset in the middle of a fill.
    stall = 10;
    exp_fill(16'h1630);
    b_read = 1'b1; b_addr = 16'h1634;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = d0_pread;
    end
    check("midfill_started", 128'(seen), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midfill_rst_pmem_read", 128'(d0_pread), 128'(0));
    check("midfill_rst_pmem_addr", 128'(d0_paddr), 128'(16'h0000));
    b_read = 1'b0;
    @(negedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    stall = 0;
    @(posedge clk); #1;
    exp_fill(16'h1630); cpu_req(1'b1, 1'b0, 16'h1634, 16'h0000, 2'b00, 16'h1632, 2);

    // Two-way instance: A, B, A, C in set 1; C must evict B.
    sel = 1'b1;
    @(posedge clk); #1;
    exp_fill(16'h0010); cpu_req(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'h0010, 2);
    exp_fill(16'h0090); cpu_req(1'b1, 1'b0, 16'h0090, 16'h0000, 2'b00, 16'h0090, 2);
    cpu_req(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'h0010, 1);
    exp_fill(16'h0110); cpu_req(1'b1, 1'b0, 16'h0110, 16'h0000, 2'b00, 16'h0110, 2);
    cpu_req(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'h0010, 1);
    exp_fill(16'h0090); cpu_req(1'b1, 1'b0, 16'h0090, 16'h0000, 2'b00, 16'h0090, 2);

    repeat (3) @(posedge clk);
    check("pmem_queue_drained", 128'(pq.size()), 128'(0));
    check("resp_queue_drained", 128'(cq.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cache_nway.md
Name: cache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache between the LC-3b CPU memory port and physical memory.
- Successor to the fixed 2-way/LRU cache. Adds configurable associativity and set count, tree pseudo-LRU replacement, asynchronous reset of all state, and invalid-way-first victim selection.
- Tag/valid/dirty/data arrays are flops inside the block, so the hit path is combinational.

Parameters:
- WAYS, 4, associativity; power of two, 2..8.
- SETS, 8, number of sets; power of two, 2..64.
- Derived, not overridable:
  - OFFSET_BITS = 4 (16-byte line = mem_bus).
  - INDEX_BITS = log2(SETS).
  - TAG_BITS = 16 - 4 - INDEX_BITS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_address  in  16 (lc3b_word)  CPU byte address; bit 0 ignored.
- mem_wdata  in  16 (lc3b_word)  CPU write data.
- mem_byte_enable  in  2 (lc3b_mem_wmask)  byte lanes for a write.
- mem_rdata  out  16 (lc3b_word)  word mem_address[3:1] of the hit line.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_address  out  16 (lc3b_word)  line address, low 4 bits zero.
- pmem_wdata  out  128 (mem_bus)  victim line.
- pmem_rdata  in  128 (mem_bus)  fill line.
- pmem_resp  in  1  physical memory done; data valid on the same cycle.

Behaviour:
- Address split: tag = addr[15:4+INDEX_BITS], index = addr[3+INDEX_BITS:4], word = addr[3:1].
- Reset (async, while rst_n=0): all valid, dirty and PLRU bits = 0; FSM = CHECK; pmem_read, pmem_write and mem_resp = 0; pmem_address = 0. Data/tag arrays are not cleared. Dirty data pending at reset is discarded.
- FSM states: CHECK, WRITEBACK, FILL.
- CHECK:
  - Hit = request active and any valid way of the indexed set has a matching tag (at most one match).
  - Read hit: mem_resp=1 in the same cycle. mem_rdata = selected word. PLRU updated at the clock edge.
  - Write hit: mem_resp=1 in the same cycle. At the clock edge, merge the enabled bytes into the word, set dirty, update PLRU.
  - mem_read and mem_write both high is treated as a write.
  - Miss: choose the victim = lowest-index invalid way, else the PLRU victim; the victim is registered.
    - Victim valid and dirty -> WRITEBACK.
    - Otherwise -> FILL.
- WRITEBACK:
  - pmem_write=1, pmem_address = {victim tag, index, 4'b0}, pmem_wdata = victim line.
  - Wait for pmem_resp; on it clear the victim's dirty bit -> FILL.
- FILL:
  - pmem_read=1, pmem_address = {request tag, index, 4'b0}.
  - On pmem_resp: victim data <= pmem_rdata, tag <= request tag, valid=1, dirty=0 -> CHECK.
  - The request then hits, so mem_resp comes exactly one cycle after the fill pmem_resp.
- Miss latency = 1 + (writeback wait) + fill wait + 1 cycles.
- pmem outputs are Moore outputs of the state: stable, and held while pmem_resp=0. pmem_read and pmem_write are never both high.
- PLRU: tree of WAYS-1 bits per set. On each access (hit or post-fill hit), every node on the path is set to point away from the accessed way. Victim = follow the pointers. WAYS=2 degenerates to a single LRU bit.
- No request active in CHECK: no state change and no PLRU update.

Decomposition:
- lc3b_types package: reuse lc3b_word, mem_bus, lc3b_mem_wmask. Add the cache_state_t enum {CHECK, WRITEBACK, FILL}.
- Sub-module plru_tree #(WAYS):
  - Combinational victim output from the current bits.
  - Next-bits output given the accessed way.
  - Instantiated once and fed by the indexed set's bits.

Test Plan (WAYS=4, SETS=8 unless noted):
- Cold read miss: after reset, read 0x1234 (index 3, tag 0x24) -> pmem_read with pmem_address=0x1230. Return word2=0xBEEF -> mem_resp one cycle after pmem_resp, mem_rdata=0xBEEF, no pmem_write.
- Write hit merge: write 0x1234, data 0x00AA, byte_enable=2'b01 -> mem_resp same cycle, no pmem activity. A following read returns 0xBEAA.
- PLRU eviction with writeback: reads to 0x12B4, 0x1334, 0x13B4 fill ways 1-3. Read 0x1434 -> victim way 0, so:
  - pmem_write at 0x1230 first, with pmem_wdata word2=0xBEAA.
  - Then pmem_read at 0x1430.
- Stalled memory: hold pmem_resp low 20 cycles during FILL -> pmem_read and pmem_address held constant, mem_resp=0 throughout.
- Reset mid-fill: drop rst_n while pmem_read=1 -> pmem_read=0 immediately, without a clock. After release, a read of the same address misses again.
- WAYS=2: reads A=0x0010, B=0x0090, A, C=0x0110 (same set) -> C evicts B. Verify by re-reading A (hit) and B (miss).
